data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface. Owns the data BRAM.

---
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port: owns the data RAM, serves one
// load/store at a time, extends sub-word loads and merges sub-word stores.
module data_mem_responder #(
  parameter int    DEPTH      = 4096,
  parameter int    RD_LATENCY = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [31:0] req_addr_in,
  input  logic        req_we_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_wdata_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_data_out,
  output logic        resp_err_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE, RESP} state_t;

  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rd1;
  logic [31:0]   r_rd2;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic          r_we;
  logic          r_unsigned;
  logic [15:0]   r_wdata;
  logic [1:0]    r_cnt;
  logic          r_valid;
  logic          r_err;
  logic [31:0]   r_data;

  logic          w_accept;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_merged;

  assign req_ready_out  = (r_state == IDLE) && !rst_in;
  assign resp_valid_out = r_valid;
  assign resp_data_out  = r_data;
  assign resp_err_out   = r_err;

  assign w_accept = req_valid_in && req_ready_out;
  assign w_idx    = req_addr_in[AW+1:2];
  assign w_err    = (req_size_in == 2'b11)
                 || ((req_size_in == 2'b01) && req_addr_in[0])
                 || ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00))
                 || (req_addr_in[31:AW+2] != '0);

  assign w_rdata = (RD_LATENCY == 2) ? r_rd2 : r_rd1;
  assign w_byte  = w_rdata[{r_lane, 3'b000} +: 8];
  assign w_half  = w_rdata[{r_lane[1], 4'b0000} +: 16];

  // Load extraction and store merge both work on the word read back at accept.
  always_comb begin
    w_load   = w_rdata;
    w_merged = w_rdata;
    case (r_size)
      2'b00: begin
        w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
      end
      default: ;
    endcase
  end

  // RAM port: no reset so contents survive it; the merge write is skipped if reset lands on it.
  always_ff @(posedge clk_in) begin
    if (w_accept) r_rd1 <= r_mem[w_idx];
    r_rd2 <= r_rd1;
    if (w_accept && req_we_in && (req_size_in == 2'b10) && !w_err)
      r_mem[w_idx] <= req_wdata_in;
    else if (!rst_in && (r_state == MERGE))
      r_mem[r_idx] <= w_merged;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx      <= w_idx;
            r_lane     <= req_addr_in[1:0];
            r_size     <= req_size_in;
            r_we       <= req_we_in;
            r_unsigned <= req_unsigned_in;
            r_wdata    <= req_wdata_in[15:0];
            r_cnt      <= 2'(RD_LATENCY - 1);
            if (w_err) begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_err   <= 1'b1;
              r_data  <= '0;
            end else if (req_we_in && (req_size_in == 2'b10)) begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_err   <= 1'b0;
              r_data  <= '0;
            end else begin
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == 2'd0) begin
            if (r_we) begin
              r_state <= MERGE;
            end else begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_err   <= 1'b0;
              r_data  <= w_load;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        MERGE: begin
          r_state <= RESP;
          r_valid <= 1'b1;
          r_err   <= 1'b0;
          r_data  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected
// responses; a negedge monitor pops and checks data, error flag and latency.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rstIn;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  int   cycle = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   pushCount = 0;
  int   respCount = 0;
  int   respBefore;

  data_mem_responder #(.DEPTH(4096), .RD_LATENCY(2), .INIT_FILE("")) dut (
    .clk_in(clk), .rst_in(rstIn),
    .req_valid_in(reqValid), .req_ready_out(reqReady),
    .req_addr_in(reqAddr), .req_we_in(reqWe), .req_size_in(reqSize),
    .req_unsigned_in(reqUnsigned), .req_wdata_in(reqWdata),
    .resp_valid_out(respValid), .resp_data_out(respData), .resp_err_out(respErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Monitor: every sampled response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rstIn && respValid) begin
      respCount++;
      if (sb.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_resp: got data 0x%08h err %0b, wanted no response", respData, respErr);
      end else begin
        monExp = sb.pop_front();
        checkOutput("resp_data", respData, monExp.data);
        checkOutput("resp_err", {31'b0, respErr}, {31'b0, monExp.err});
        checkOutput("resp_latency", 32'(cycle - monExp.acc + 1), 32'(monExp.lat));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr, input int expLat,
                               input bit track, input bit hold);
    int waited = 0;
    @(negedge clk);
    reqAddr = addr; reqWe = we; reqSize = size; reqUnsigned = uns; reqWdata = wdata;
    reqValid = 1'b1;
    while (!reqReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady) begin
      checkCount++;
      $display("[TB] FAIL ready_timeout: got ready 0 for 50 cycles, wanted 1 (addr 0x%08h)", addr);
      reqValid = 1'b0;
      return;
    end
    if (track) begin
      sb.push_back('{data: expData, err: expErr, lat: expLat, acc: cycle + 1});
      pushCount++;
    end
    @(posedge clk);
    if (!hold) begin
      #1 reqValid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain_timeout: got %0d outstanding, wanted 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rstIn = 1'b1; reqValid = 1'b0; reqAddr = '0; reqWe = 1'b0;
    reqSize = 2'b10; reqUnsigned = 1'b0; reqWdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'b0, reqReady}, 32'd0);
    checkOutput("reset_valid", {31'b0, respValid}, 32'd0);
    checkOutput("reset_data", respData, 32'd0);
    checkOutput("reset_err", {31'b0, respErr}, 32'd0);
    rstIn = 1'b0;
    #1 checkOutput("ready_after_reset", {31'b0, reqReady}, 32'd1);

    // Word store and load.
    applyStimulus(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b1, 1'b0);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b0);
    waitDrain();

    // Byte store merge and signed/unsigned byte loads.
    applyStimulus(32'h11, 1'b1, 2'b00, 1'b0, 32'h000000A5, 32'h0, 1'b0, 4, 1'b1, 1'b0);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADA5EF, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus(32'h11, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus(32'h11, 1'b0, 2'b00, 1'b1, 32'h0, 32'h000000A5, 1'b0, 3, 1'b1, 1'b0);
    waitDrain();

    // Half store ignores upper wdata.
    applyStimulus(32'h12, 1'b1, 2'b01, 1'b0, 32'hFFFF1234, 32'h0, 1'b0, 4, 1'b1, 1'b0);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1234A5EF, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus(32'h12, 1'b0, 2'b01, 1'b0, 32'h0, 32'h00001234, 1'b0, 3, 1'b1, 1'b0);
    waitDrain();

    // Error cases leave memory untouched.
    applyStimulus(32'h13, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(32'h11, 1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(32'h10, 1'b1, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(32'h4000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    applyStimulus(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1234A5EF, 1'b0, 3, 1'b1, 1'b0);
    waitDrain();

    // Reset during MERGE aborts the byte store with no response.
    applyStimulus(32'h20, 1'b1, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 1, 1'b1, 1'b0);
    waitDrain();
    respBefore = respCount;
    applyStimulus(32'h20, 1'b1, 2'b00, 1'b0, 32'h00000077, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rstIn = 1'b1;
    @(negedge clk);
    rstIn = 1'b0;
    #1 checkOutput("ready_after_abort", {31'b0, reqReady}, 32'd1);
    checkOutput("valid_after_abort", {31'b0, respValid}, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("no_resp_on_abort", 32'(respCount - respBefore), 32'd0);
    applyStimulus(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0, 3, 1'b1, 1'b0);
    waitDrain();

    // Valid held high across a mixed sequence.
    applyStimulus(32'h40, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1, 1'b1);
    applyStimulus(32'h43, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFFCA, 1'b0, 3, 1'b1, 1'b1);
    applyStimulus(32'h42, 1'b1, 2'b01, 1'b0, 32'h9999BEEF, 32'h0, 1'b0, 4, 1'b1, 1'b1);
    applyStimulus(32'h42, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000BEEF, 1'b0, 3, 1'b1, 1'b1);
    applyStimulus(32'h40, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFFF00D, 1'b0, 3, 1'b1, 1'b1);
    applyStimulus(32'h41, 1'b1, 2'b00, 1'b0, 32'h00000012, 32'h0, 1'b0, 4, 1'b1, 1'b1);
    applyStimulus(32'h40, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b1);
    applyStimulus(32'h40, 1'b0, 2'b10, 1'b0, 32'h0, 32'hBEEF120D, 1'b0, 3, 1'b1, 1'b0);
    waitDrain();

    checkOutput("resp_count", 32'(respCount), 32'(pushCount));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
